// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one FullAdder cell adds two WIDTH-bit operands LSB first, one bit per clock.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' input that computes a - b on the same cell.

module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  logic             w_sub;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;
  logic             w_cell_s;
  logic             w_cell_c;
  logic             w_last;

`ifdef SERIAL_ADD_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif

  // Subtraction is a + ~b + 1, so the forced carry-in replaces cin.
  assign w_b_load = w_sub ? ~b : b;
  assign w_c_load = w_sub ? 1'b1 : cin;
  assign w_last   = (r_cnt == CNT_W'(WIDTH-1));

  FullAdder u_cell (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .cin  (r_carry),
    .sum  (w_cell_s),
    .cout (w_cell_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          r_carry <= w_cell_c;
          r_cnt   <= r_cnt + CNT_W'(1);
          // The held result is discarded on the first RUN edge, not on accept.
          if (r_cnt == '0) begin
            r_sum  <= {w_cell_s, {(WIDTH-1){1'b0}}};
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
          end else begin
            r_sum <= {w_cell_s, r_sum[WIDTH-1:1]};
          end
          if (w_last) begin
            r_cout  <= w_cell_c;
            r_ovf   <= r_carry ^ w_cell_c;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign cout  = r_cout;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: driver pushes model results, a negedge monitor pops on done.
// Define SERIAL_ADD_SUB_EN to also exercise the subtract mode.

module tb_serial_add_ctrl;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         ready, busy, done, cout, ovf;
  logic [W-1:0] sum;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t sb[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow = result outside the signed range.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic s);
    exp_t   e;
    longint ux, uy, sx, sy, tot, sres;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      tot    = ux - uy;
      e.cout = (ux >= uy);
      sres   = sx - sy;
    end else begin
      tot    = ux + uy + longint'(c);
      e.cout = (tot >= (longint'(1) << W));
      sres   = sx + sy + longint'(c);
    end
    e.sum = W'(tot);
    e.ovf = (sres > (longint'(1) << (W-1)) - 1) || (sres < -(longint'(1) << (W-1)));
    e.due = 0;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input logic s, input bit push);
    exp_t e;
    int   guard = 0;
    while (!ready) begin
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        n_cmp++;
        n_fail++;
        $display("FAIL ready_timeout: got ready=0 expected ready=1 within 100 cycles");
        return;
      end
    end
    start = 1'b1;
    a = x;
    b = y;
    cin = c;
`ifdef SERIAL_ADD_SUB_EN
    sub = s;
`endif
    if (push) begin
      e = model(x, y, c, s);
      e.due = cyc + 1 + W;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'($urandom);
`endif
  endtask

  // Monitor: result checks on done, hold checks while ready, busy length, done width.
  initial begin
    logic [W-1:0] l_sum;
    logic         l_cout, l_ovf, p_ready, p_done;
    int           busy_cnt;
    exp_t         e;
    l_sum = '0; l_cout = 1'b0; l_ovf = 1'b0;
    p_ready = 1'b1; p_done = 1'b0; busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        l_sum = '0; l_cout = 1'b0; l_ovf = 1'b0;
        p_ready = 1'b1; p_done = 1'b0; busy_cnt = 0;
      end else begin
        if (p_done) chk("done_width", done, 0);
        if (p_ready && busy) begin
          chk("hold_sum_first_run", sum, l_sum);
          chk("hold_cout_first_run", cout, l_cout);
        end
        if (busy) busy_cnt++;
        if (done) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no pending result, sum=%0h", sum);
          end else begin
            e = sb.pop_front();
            chk("sum", sum, e.sum);
            chk("cout", cout, e.cout);
            chk("ovf", ovf, e.ovf);
            chk("done_latency", cyc, e.due);
            chk("busy_cycles", busy_cnt, W);
          end
          l_sum = sum; l_cout = cout; l_ovf = ovf;
          busy_cnt = 0;
        end else if (ready) begin
          chk("hold_sum", sum, l_sum);
          chk("hold_ovf", ovf, l_ovf);
        end
        p_ready = ready;
        p_done = done;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    logic s;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    rst = 1'b0;
    @(negedge clk);

    issue(8'd23, 8'd19, 1'b0, 1'b0, 1'b1);
    repeat (12) @(negedge clk);

    // Reset in the 3rd RUN cycle; nothing is pushed so any later done is flagged.
    issue(8'h55, 8'h0F, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrun_rst_ready", ready, 1);
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_sum", sum, 0);
    chk("midrun_rst_cout", cout, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("post_rst_no_done", done, 0);
    end

    issue(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    issue(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
    issue(8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    repeat (12) @(negedge clk);

    // Start pulse during RUN with other operands must be ignored.
    issue(8'd40, 8'd2, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Second issue waits for ready, which first rises in the DONE cycle: back-to-back.
    issue(8'd100, 8'd27, 1'b0, 1'b0, 1'b1);
    issue(8'd3, 8'd4, 1'b0, 1'b0, 1'b1);

`ifdef SERIAL_ADD_SUB_EN
    issue(8'd10, 8'd3, 1'b0, 1'b1, 1'b1);
    issue(8'h80, 8'h01, 1'b1, 1'b1, 1'b1);
`endif

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
`ifdef SERIAL_ADD_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      issue(W'($urandom), W'($urandom), 1'($urandom), s, 1'b1);
    end

    guard = 0;
    while (sb.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
    end
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller. Time-shares one single-bit full-adder cell to add two WIDTH-bit operands, LSB first, one bit per clock.
- Owns operand/result shift registers, the carry flip-flop, bit counter and start/done handshake.
- Sits between a requester (CPU/ALU sequencer or bench) and the existing FullAdder cell, which it instantiates as its bit cell.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- a  input  WIDTH  operand A, sampled on the accept edge.
- b  input  WIDTH  operand B, sampled on the accept edge.
- cin  input  1  carry-in, sampled on the accept edge.
- ready  output  1  high in IDLE and DONE (can accept start).
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse: the result has just become valid.
- sum  output  WIDTH  result; held stable from done until the next accept.
- cout  output  1  final carry-out; held with sum.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB; held with sum.

Behaviour:
- Interface decided: one clock, clk. Reset rst is asynchronous and active-high.
- Reset (asynchronous, any state, including mid-RUN): state=IDLE; ready=1, busy=0, done=0; sum=0, cout=0, ovf=0; internal shift registers, carry FF and counter cleared. Partial results are discarded.
- States: IDLE, RUN, DONE.
- IDLE to RUN on start=1:
  - Latch a and b into shift registers.
  - Carry FF <= cin; counter <= 0.
  - sum/cout/ovf are not cleared until the first RUN edge.
- RUN, each cycle:
  - Bit cell inputs: A_sr[0], B_sr[0], carry FF.
  - Its sum bit shifts into the result register MSB; the result register shifts right.
  - A_sr and B_sr shift right; carry FF <= cell carry; counter increments.
  - On the edge where the counter reaches WIDTH-1:
    - Record carry-in of the MSB cell for ovf.
    - cout <= cell carry.
    - Go to DONE; done=1 for exactly that next cycle.
- Latency: accept edge N; sum/cout/ovf valid and done=1 in cycle N+WIDTH+1 (WIDTH RUN cycles).
- DONE, one cycle only:
  - start=1 accepts a new operation immediately (back-to-back, no idle bubble); go to RUN.
  - Otherwise go to IDLE. The result stays held in both cases until RUN overwrites it.
- start while busy=1 is ignored and not queued.
- Arithmetic is modulo 2^WIDTH; cout carries the overflow bit. Operand changes during RUN have no effect.
- No combinational path from start to ready/busy/done.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), sampled on the accept edge.
  - sub=1 latches ~b and forces the carry FF to 1 (cin ignored), giving a - b. cout=1 means no borrow; ovf is the signed-subtract overflow.
  - sub=0 behaves as the base block.
- Undefined: no sub port; add only.

Test Plan (WIDTH=8):
- Reset mid-RUN: start a=8'h55, b=8'h0F. Assert rst on the 3rd RUN cycle. Required: ready=1, busy=0, sum=0 immediately. After release, idle with no done.
- Simple add: a=8'd23, b=8'd19, cin=0. Required: busy for 8 cycles; done pulse 9 cycles after the accept edge; sum=8'd42, cout=0, ovf=0.
- Wrap/carry: a=8'hFF, b=8'h01, cin=0. Required: sum=8'h00, cout=1, ovf=0. Then a=8'h7F, b=8'h01. Required: sum=8'h80, cout=0, ovf=1.
- cin path: a=8'h00, b=8'h00, cin=1. Required: sum=8'h01, cout=0.
- Handshake:
  - Pulse start again during RUN with different operands. Required: ignored; the original result is delivered.
  - Hold start=1 in the DONE cycle with a=8'd3, b=8'd4. Required: second done exactly 9 cycles later, sum=8'd7; the first result stays stable until the first RUN edge.
- SERIAL_ADD_SUB_EN defined: sub=1, a=8'd10, b=8'd3. Required: sum=8'd7, cout=1. Then a=8'h80, b=8'h01. Required: sum=8'h7F, ovf=1.
